// File: rtl/bks_pkg.sv
// Shared types for the Brent-Kung subtractor: operand width and the (propagate, generate) pair.
package bks_pkg;

  localparam int BKS_W = 16;

  typedef struct packed {
    logic p;
    logic g;
  } bks_pg_t;

  typedef bks_pg_t [BKS_W-1:0] bks_pg_vec_t;

endpackage

// File: rtl/bks_pg_cell.sv
// Brent-Kung black cell: merges a high group (p_hi, g_hi) with the adjacent low group (p_lo, g_lo).
module bks_pg_cell (
  input  logic p_hi_i,
  input  logic g_hi_i,
  input  logic p_lo_i,
  input  logic g_lo_i,
  output logic p_o,
  output logic g_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/bks_sub16_pipe.sv
// Two-stage 16-bit Brent-Kung subtractor, diff = a - b - bin, with valid/ready on both sides.
// Define BKS_SUB_SAT_EN to clamp diff to zero whenever the subtraction borrows.
module bks_sub16_pipe
  import bks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  if (WIDTH != BKS_W) begin : g_bad_width
    $error("bks_sub16_pipe: the prefix tree is hand-built for WIDTH=16 only");
  end

  // ---------------- Stage 1: bit p/g, level-1 pairs, level-2 groups ----------------
  bks_pg_vec_t   pg_d, pg_q;
  bks_pg_t [7:0] l1_d, l1_q;
  bks_pg_t [3:0] l2_d, l2_q;
  logic          cin_q;

  always_comb begin
    for (int i = 0; i < BKS_W; i++) begin
      pg_d[i].p = a[i] ^ ~b[i];
      pg_d[i].g = a[i] & ~b[i];
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_l1
    bks_pg_cell u_cell (
      .p_hi_i(pg_d[2*k+1].p), .g_hi_i(pg_d[2*k+1].g),
      .p_lo_i(pg_d[2*k].p),   .g_lo_i(pg_d[2*k].g),
      .p_o   (l1_d[k].p),     .g_o   (l1_d[k].g)
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_l2
    bks_pg_cell u_cell (
      .p_hi_i(l1_d[2*k+1].p), .g_hi_i(l1_d[2*k+1].g),
      .p_lo_i(l1_d[2*k].p),   .g_lo_i(l1_d[2*k].g),
      .p_o   (l2_d[k].p),     .g_o   (l2_d[k].g)
    );
  end

  // ---------------- Stage 2: remaining prefix levels and sum ----------------
  bks_pg_t [1:0] l3;      // [7:0], [15:8]
  bks_pg_t       pre_15_0, pre_5_0, pre_9_0, pre_11_0, pre_13_0;
  bks_pg_t [7:0] odd_pre; // prefix [2k+1:0]
  bks_pg_t [7:0] even_pre;// prefix [2k:0]
  bks_pg_vec_t   pre;
  logic [BKS_W:0]   c;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             bout_d, bout_q, ovf_d, ovf_q;

  for (genvar k = 0; k < 2; k++) begin : g_l3
    bks_pg_cell u_cell (
      .p_hi_i(l2_q[2*k+1].p), .g_hi_i(l2_q[2*k+1].g),
      .p_lo_i(l2_q[2*k].p),   .g_lo_i(l2_q[2*k].g),
      .p_o   (l3[k].p),       .g_o   (l3[k].g)
    );
  end

  bks_pg_cell u_p15 (.p_hi_i(l3[1].p),   .g_hi_i(l3[1].g),   .p_lo_i(l3[0].p),    .g_lo_i(l3[0].g),
                     .p_o(pre_15_0.p),   .g_o(pre_15_0.g));
  bks_pg_cell u_p11 (.p_hi_i(l2_q[2].p), .g_hi_i(l2_q[2].g), .p_lo_i(l3[0].p),    .g_lo_i(l3[0].g),
                     .p_o(pre_11_0.p),   .g_o(pre_11_0.g));
  bks_pg_cell u_p5  (.p_hi_i(l1_q[2].p), .g_hi_i(l1_q[2].g), .p_lo_i(l2_q[0].p),  .g_lo_i(l2_q[0].g),
                     .p_o(pre_5_0.p),    .g_o(pre_5_0.g));
  bks_pg_cell u_p9  (.p_hi_i(l1_q[4].p), .g_hi_i(l1_q[4].g), .p_lo_i(l3[0].p),    .g_lo_i(l3[0].g),
                     .p_o(pre_9_0.p),    .g_o(pre_9_0.g));
  bks_pg_cell u_p13 (.p_hi_i(l1_q[6].p), .g_hi_i(l1_q[6].g), .p_lo_i(pre_11_0.p), .g_lo_i(pre_11_0.g),
                     .p_o(pre_13_0.p),   .g_o(pre_13_0.g));

  assign odd_pre = {pre_15_0, pre_13_0, pre_11_0, pre_9_0, l3[0], pre_5_0, l2_q[0], l1_q[0]};
  assign even_pre[0] = pg_q[0];

  for (genvar k = 1; k < 8; k++) begin : g_even
    bks_pg_cell u_cell (
      .p_hi_i(pg_q[2*k].p),     .g_hi_i(pg_q[2*k].g),
      .p_lo_i(odd_pre[k-1].p),  .g_lo_i(odd_pre[k-1].g),
      .p_o   (even_pre[k].p),   .g_o   (even_pre[k].g)
    );
  end

  for (genvar k = 0; k < 8; k++) begin : g_pre
    assign pre[2*k]   = even_pre[k];
    assign pre[2*k+1] = odd_pre[k];
  end

  assign c[0] = cin_q;
  for (genvar i = 0; i < BKS_W; i++) begin : g_carry
    assign c[i+1]    = pre[i].g | (pre[i].p & cin_q);
    assign diff_d[i] = pg_q[i].p ^ c[i];
  end

  assign bout_d = ~c[BKS_W];
  assign ovf_d  = c[BKS_W] ^ c[BKS_W-1];

  // Odd pairs and odd-bit generates are fully absorbed into the level-2 groups.
  logic unused_pg;
  assign unused_pg = ^{l1_q[1], l1_q[3], l1_q[5], l1_q[7],
                       pg_q[1].g, pg_q[3].g, pg_q[5].g, pg_q[7].g,
                       pg_q[9].g, pg_q[11].g, pg_q[13].g, pg_q[15].g};

  // ---------------- Pipeline control ----------------
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, accept;
  logic [WIDTH-1:0] diff_res;

`ifdef BKS_SUB_SAT_EN
  assign diff_res = c[BKS_W] ? diff_d : '0;
`else
  assign diff_res = diff_d;
`endif

  assign s2_adv    = !s2_valid_q | out_ready;
  assign s1_adv    = !s1_valid_q | s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid & s1_adv;
  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          diff_q <= diff_res;
          bout_q <= bout_d;
          ovf_q  <= ovf_d;
        end
      end
      if (s1_adv) s1_valid_q <= accept;
    end
  end

  // NOTE: stage-1 data is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pg_q  <= pg_d;
      l1_q  <= l1_d;
      l2_q  <= l2_d;
      cin_q <= ~bin;
    end
  end

endmodule

// File: tb/tb_bks_sub16_pipe.sv
// Self-checking bench for bks_sub16_pipe: directed corner cases, backpressure, reset, random stream.
module tb_bks_sub16_pipe;

`ifdef BKS_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, bin;
  logic [15:0] a, b, diff;
  logic        out_valid, out_ready, bout, ovf;

  always #5 clk = ~clk;

  bks_sub16_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain integer arithmetic.
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] r;
    int          s;
    logic        o;
    r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    o = (s > 32767) || (s < -32768);
    if (SAT && r[16]) r[15:0] = 16'h0000;
    return {o, r[16], r[15:0]};
  endfunction

  logic [17:0] sb_q[$];
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out;

  // One cycle window: drive inputs, let combinational ready settle, then score the transfers.
  task automatic step_at(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ibin, input logic ior);
    logic [17:0] exp;
    in_valid = iv; a = ia; b = ib; bin = ibin; out_ready = ior;
    #1;
    if (prev_stall) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {14'd0, ovf, bout, diff}, {14'd0, prev_out});
    end
    if (in_valid && in_ready) sb_q.push_back(ref_sub(ia, ib, ibin));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check("result", {14'd0, ovf, bout, diff}, {14'd0, exp});
        n_out++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {ovf, bout, diff};
  endtask

  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ibin, input logic ior);
    @(negedge clk);
    step_at(iv, ia, ib, ibin, ior);
  endtask

  task automatic directed(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ibin, input logic [15:0] ed, input logic eb, input logic eo);
    step(1'b1, ia, ib, ibin, 1'b1);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int base;
    int sent;
    int stall_left;
    bit bp_started;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_diff", {16'd0, diff}, 32'd0);
    check("reset_bout", {31'd0, bout}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    directed("basic", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    directed("underflow", 16'h0000, 16'h0001, 1'b0, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);
    directed("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed("borrow_in", 16'h1234, 16'h1234, 1'b1, SAT ? 16'h0000 : 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: 5 back-to-back operands, 3-cycle stall from the first out_valid.
    base = n_out; sent = 0; stall_left = 0; bp_started = 1'b0;
    for (int cyc = 0; cyc < 40 && (n_out - base) < 5; cyc++) begin
      @(negedge clk);
      if (!bp_started && out_valid) begin
        bp_started = 1'b1;
        stall_left = 3;
      end
      step_at(sent < 5, 16'h1000 * 16'(sent + 1) + 16'($urandom_range(0, 255)),
              16'($urandom), 1'($urandom_range(0, 1)), stall_left == 0);
      if (stall_left > 0) begin
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        stall_left--;
      end
      if (in_valid && in_ready) sent++;
    end
    check("bp_count", 32'(n_out - base), 32'd5);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Reset with both stages full.
    step(1'b1, 16'h4321, 16'h0101, 1'b0, 1'b0);
    step(1'b1, 16'h0001, 16'h0002, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    sb_q.delete();
    prev_stall = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_diff", {16'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random stream with random valid/ready.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    end
    check("random_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
